// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci job scheduler.
//   DEFAULT_DATA_W : default width of limits and terms
//   state_e        : scheduler states (IDLE arbitrates, RUN streams one job)
//   id_width()     : width of a requester ID for a given requester count
package fib_pkg;

    localparam int DEFAULT_DATA_W = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Never returns 0, so an ID field always has at least one bit.
    function automatic int id_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/fib_core.sv
// Fibonacci datapath: holds the two most recent terms and presents their sum.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   load         : seed curr=0, next=1 (first sum is 1)
//   step         : advance curr<=next, next<=sum
//   sum          : curr+next truncated to DATA_W bits
//   carry        : carry-out of curr+next
module fib_core
    import fib_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    output logic [DATA_W-1:0] sum,
    output logic              carry
);

    logic [DATA_W-1:0] curr_q, curr_d;
    logic [DATA_W-1:0] next_q, next_d;

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        {carry, sum} = {1'b0, curr_q} + {1'b0, next_q};
        curr_d       = curr_q;
        next_d       = next_q;
        if (load) begin
            curr_d = '0;
            next_d = DATA_W'(1);
        end else if (step) begin
            curr_d = next_q;
            next_d = sum;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its d input from before the edge, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            curr_q <= '0;
            next_q <= '0;
        end else begin
            curr_q <= curr_d;
            next_q <= next_d;
        end
    end

endmodule

// File: rtl/fib_job_sched.sv
// Round-robin scheduler sharing one Fibonacci datapath among NUM_REQ requesters.
//   clock, reset         : rising-edge clock, synchronous active-high reset
//   req_valid[NUM_REQ]   : per-requester job request
//   req_limit            : per-requester limit, slice i belongs to requester i
//   req_ready[NUM_REQ]   : one-hot job-accept pulse (combinational, IDLE only)
//   out_valid/out_ready  : term beat handshake
//   out_data             : Fibonacci term (1, 2, 3, 5, ...)
//   out_id               : requester owning the beat
//   out_last             : final beat of the job (term >= limit or overflow)
//   out_ovf              : term overflowed DATA_W bits
//   busy                 : a job is in progress
module fib_job_sched
    import fib_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_limit,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [ID_W-1:0]           out_id,
    output logic                      out_last,
    output logic                      out_ovf,
    output logic                      busy
);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   owner_q, owner_d;
    logic [DATA_W-1:0] limit_q, limit_d;

    logic              core_load;
    logic              core_step;
    logic [DATA_W-1:0] core_sum;
    logic              core_carry;

    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [DATA_W-1:0] limit_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_limit
        assign limit_arr[i] = req_limit[i*DATA_W +: DATA_W];
    end

    // First requesting index at or above rr_ptr, wrapping past NUM_REQ-1.
    always_comb begin : rr_search
        int              cand;
        logic [ID_W-1:0] cand_id;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_id     = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = int'(rr_ptr_q) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_id = ID_W'(cand);
            if (!grant_found && req_valid[cand_id]) begin
                grant_found = 1'b1;
                grant_idx   = cand_id;
            end
        end
    end

    always_comb begin : fsm_next
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        limit_d   = limit_q;
        core_load = 1'b0;
        core_step = 1'b0;
        req_ready = '0;
        out_valid = 1'b0;
        out_data  = '0;
        out_id    = '0;
        out_last  = 1'b0;
        out_ovf   = 1'b0;
        busy      = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Reset masks the accept pulse so no requester believes it
                // was granted on a cycle whose capture is discarded.
                if (grant_found && !reset) begin
                    req_ready[grant_idx] = 1'b1;
                    owner_d              = grant_idx;
                    limit_d              = limit_arr[grant_idx];
                    core_load            = 1'b1;
                    state_d              = RUN;
                end
            end
            RUN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = core_sum;
                out_id    = owner_q;
                out_ovf   = core_carry;
                out_last  = (core_sum >= limit_q) || core_carry;
                if (out_ready) begin
                    if (out_last) begin
                        state_d  = IDLE;
                        rr_ptr_d = (owner_q == ID_W'(NUM_REQ - 1)) ? '0 : owner_q + ID_W'(1);
                    end else begin
                        core_step = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            limit_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            limit_q  <= limit_d;
        end
    end

    fib_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .clock (clock),
        .reset (reset),
        .load  (core_load),
        .step  (core_step),
        .sum   (core_sum),
        .carry (core_carry)
    );

endmodule

// File: tb/tb_fib_job_sched.sv
// Self-checking bench for fib_job_sched: table of single jobs with known
// results, hand sequences for arbitration / reset corner cases, and a
// randomized run scored against a transaction-level model.
module tb_fib_job_sched;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int ID_W    = 2;

    logic                      clock = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_limit;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_W-1:0]         out_data;
    logic [ID_W-1:0]           out_id;
    logic                      out_last;
    logic                      out_ovf;
    logic                      busy;

    int n_checks = 0;
    int n_errors = 0;

    // Model: pending expected beats, encoded id<<10 | ovf<<9 | last<<8 | data.
    int   exp_q[$];
    bit   m_busy = 1'b0;
    int   m_ptr  = 0;
    bit   stalled = 1'b0;
    int   stall_snap = 0;

    always #5 clock = ~clock;

    fib_job_sched #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .ID_W    (ID_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_limit (req_limit),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_last  (out_last),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Leaves the bench 1 time unit after a rising edge, where inputs change.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expected beats of one job: Fibonacci terms 1, 2, 3, 5, ... until a term
    // reaches the limit or no longer fits in DATA_W bits.
    function automatic void push_job(input int limit, input int id);
        int a;
        int b;
        int s;
        a = 0;
        b = 1;
        for (int k = 0; k < 64; k++) begin
            s = a + b;
            if (s >= (1 << DATA_W)) begin
                exp_q.push_back((id << 10) | (1 << 9) | (1 << 8) | (s % (1 << DATA_W)));
                break;
            end
            if (s >= limit) begin
                exp_q.push_back((id << 10) | (1 << 8) | s);
                break;
            end
            exp_q.push_back((id << 10) | s);
            a = b;
            b = s;
        end
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_ptr   = 0;
        stalled = 1'b0;
        exp_q.delete();
    endtask

    // Samples the current cycle, compares against the model, advances the
    // model as the coming clock edge will. Returns the granted id or -1.
    task automatic model_cycle(output int granted);
        int                 g;
        int                 cur;
        logic [NUM_REQ-1:0] exp_ready;
        #2;
        granted = -1;
        if (!m_busy) begin
            g = -1;
            for (int k = 0; k < NUM_REQ; k++) begin
                int c;
                c = (m_ptr + k) % NUM_REQ;
                if (g < 0 && req_valid[c]) g = c;
            end
            exp_ready = '0;
            if (g >= 0) exp_ready[g] = 1'b1;
            check("grant", 32'(req_ready), 32'(exp_ready));
            check("idle_flags", {30'b0, busy, out_valid}, 32'd0);
            if (g >= 0) begin
                push_job(int'(req_limit[g*DATA_W +: DATA_W]), g);
                m_busy  = 1'b1;
                granted = g;
            end
            stalled = 1'b0;
        end else if (exp_q.size() == 0) begin
            check("model_underrun", 32'd1, 32'd0);
            m_busy = 1'b0;
        end else begin
            cur = {20'b0, out_id, out_ovf, out_last, out_data};
            check("run_flags", {26'b0, req_ready, busy, out_valid}, 32'd3);
            check("beat", cur, exp_q[0]);
            if (stalled) check("hold", cur, stall_snap);
            stalled    = !out_ready;
            stall_snap = cur;
            if (out_ready) begin
                if (((exp_q[0] >> 8) & 1) == 1) begin
                    m_busy = 1'b0;
                    m_ptr  = (((exp_q[0] >> 10) & ((1 << ID_W) - 1)) + 1) % NUM_REQ;
                end
                void'(exp_q.pop_front());
            end
        end
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) tick();
        reset = 1'b0;
        model_reset();
    endtask

    // One job from requester id; reports what the DUT emitted.
    task automatic run_job(input int id, input int limit, input bit rand_ready,
                           output int beats, output int last_data, output int last_ovf);
        int g;
        bit done;
        beats     = 0;
        last_data = -1;
        last_ovf  = -1;
        done      = 1'b0;
        req_limit[id*DATA_W +: DATA_W] = DATA_W'(limit);
        req_valid[id] = 1'b1;
        for (int guard = 0; guard < 200 && !done; guard++) begin
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            model_cycle(g);
            if (out_valid && out_ready) begin
                beats++;
                last_data = int'(out_data);
                last_ovf  = int'(out_ovf);
                if (out_last) done = 1'b1;
            end
            tick();
            if (g == id) req_valid[id] = 1'b0;
        end
        if (!done) check("job_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        int id;
        int limit;
        int n_beats;
        int last_data;
        int ovf;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int beats, ldata, lovf, g, n, gap, first_cycle, hs;
        int ord[4];
        int gid[2];
        int gcyc[2];
        logic [NUM_REQ-1:0] pend;

        vecs[0] = '{0,  10,  6,  13, 0};
        vecs[1] = '{1,   0,  1,   1, 0};
        vecs[2] = '{2,   1,  1,   1, 0};
        vecs[3] = '{3,   2,  2,   2, 0};
        vecs[4] = '{0,  13,  6,  13, 0};
        vecs[5] = '{1,  14,  7,  21, 0};
        vecs[6] = '{2, 233, 12, 233, 0};
        vecs[7] = '{3, 255, 13, 121, 1};

        reset     = 1'b1;
        req_valid = '0;
        req_limit = '0;
        out_ready = 1'b0;

        // Reset state.
        tick();
        tick();
        #2;
        check("reset_outputs",
              {19'b0, req_ready, out_valid, out_data, out_id, out_last, out_ovf, busy}, 32'd0);
        tick();
        reset = 1'b0;
        model_reset();

        // Table of single jobs.
        foreach (vecs[i]) begin
            run_job(vecs[i].id, vecs[i].limit, 1'b0, beats, ldata, lovf);
            check($sformatf("tbl%0d_beats", i), beats, vecs[i].n_beats);
            check($sformatf("tbl%0d_last", i), ldata, vecs[i].last_data);
            check($sformatf("tbl%0d_ovf", i), lovf, vecs[i].ovf);
        end

        // Backpressure: limit 20 with random out_ready.
        run_job(1, 20, 1'b1, beats, ldata, lovf);
        check("bp_beats", beats, 7);
        check("bp_last", ldata, 21);

        // Round-robin between requesters 0 and 2, both held valid.
        do_reset(1);
        req_limit[0*DATA_W +: DATA_W] = 8'd2;
        req_limit[2*DATA_W +: DATA_W] = 8'd2;
        req_valid = 4'b0101;
        out_ready = 1'b1;
        n = 0;
        for (int guard = 0; guard < 100 && !(n >= 4 && !m_busy); guard++) begin
            model_cycle(g);
            if (g >= 0) begin
                if (n < 4) ord[n] = g;
                n++;
            end
            tick();
            if (n >= 4) req_valid = '0;
        end
        check("rr_count", n, 4);
        check("rr_0", ord[0], 0);
        check("rr_1", ord[1], 2);
        check("rr_2", ord[2], 0);
        check("rr_3", ord[3], 2);

        // Single-beat jobs back to back: next pending grant on the next IDLE cycle.
        do_reset(1);
        req_limit[1*DATA_W +: DATA_W] = 8'd1;
        req_limit[3*DATA_W +: DATA_W] = 8'd0;
        req_valid = 4'b1010;
        n = 0;
        for (int cyc = 0; cyc < 40 && !(n >= 2 && !m_busy); cyc++) begin
            model_cycle(g);
            if (g >= 0 && n < 2) begin
                gid[n]  = g;
                gcyc[n] = cyc;
                n++;
            end
            tick();
            if (g >= 0) req_valid[g] = 1'b0;
        end
        check("edge_count", n, 2);
        gap = gcyc[1] - gcyc[0];
        check("edge_first", gid[0], 1);
        check("edge_second", gid[1], 3);
        check("edge_gap", gap, 2);

        // Reset mid-job after the third handshake; rr pointer must return to 0.
        do_reset(1);
        run_job(2, 2, 1'b0, beats, ldata, lovf);
        req_limit[3*DATA_W +: DATA_W] = 8'd100;
        req_valid[3] = 1'b1;
        hs = 0;
        first_cycle = 1;
        for (int guard = 0; guard < 40 && hs < 3; guard++) begin
            model_cycle(g);
            if (out_valid && out_ready) hs++;
            tick();
            if (g == 3) req_valid[3] = 1'b0;
        end
        check("pre_reset_hs", hs, 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        req_limit[1*DATA_W +: DATA_W] = 8'd3;
        req_limit[3*DATA_W +: DATA_W] = 8'd3;
        req_valid = 4'b1010;
        pend = 4'b1010;
        model_cycle(g);
        check("reset_abort", {30'b0, out_valid, out_last}, 32'd0);
        check("post_reset_grant", 32'(req_ready), 32'b0010);
        for (int guard = 0; guard < 60 && (pend != '0 || m_busy); guard++) begin
            tick();
            if (g >= 0) begin
                req_valid[g] = 1'b0;
                pend[g]      = 1'b0;
            end
            model_cycle(g);
        end
        tick();

        // Randomized traffic against the model.
        do_reset(1);
        req_valid = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            for (int r = 0; r < NUM_REQ; r++) begin
                if (!req_valid[r] && $urandom_range(0, 5) == 0) begin
                    req_limit[r*DATA_W +: DATA_W] = ($urandom_range(0, 9) == 0)
                        ? DATA_W'($urandom_range(0, 255)) : DATA_W'($urandom_range(0, 30));
                    req_valid[r] = 1'b1;
                end
            end
            model_cycle(g);
            tick();
            if (g >= 0) req_valid[g] = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
